gpio_h0_arbiter: RTL and testbench



---
 rtl/gpio_arb_pkg.sv | 20 ++
 rtl/rr_pick.sv | 36 +++
 rtl/gpio_h0_arbiter.sv | 137 +++++++++++++
 tb/tb_gpio_h0_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_arb_pkg.sv
// Shared types and width helpers for the gpio_h0 line arbiter.
// Combinational helpers only; no state, no flow control.
package gpio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_e;

  localparam int DEF_NREQ     = 4;
  localparam int DEF_MAX_HOLD = 64;
  localparam int DEF_TURN_CYC = 2;

  // Counter/index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first eligible index at or after rr_ptr_i, scanning upward with wrap.
// Purely combinational; no backpressure.
module rr_pick
  import gpio_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] elig_i,
  input  logic [IW-1:0]   rr_ptr_i,
  output logic [NREQ-1:0] win_onehot_o,
  output logic [IW-1:0]   win_idx_o,
  output logic            win_vld_o
);

  logic [IW:0] cand;

  // Scan from the far end back toward rr_ptr so the closest eligible index wins last.
  always_comb begin
    cand         = '0;
    win_onehot_o = '0;
    win_idx_o    = '0;
    win_vld_o    = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_i} + (IW+1)'(k);
      if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
      if (elig_i[cand[IW-1:0]]) begin
        win_vld_o                   = 1'b1;
        win_idx_o                   = cand[IW-1:0];
        win_onehot_o                = '0;
        win_onehot_o[cand[IW-1:0]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpio_h0_arbiter.sv
// Shares the MCU gpio_h0 line among NREQ requesters: round-robin, bounded tenure, idle turnaround.
// Grant and data are 1 cycle after sampling; requests simply wait while the MCU drives or the line is busy.
module gpio_h0_arbiter
  import gpio_arb_pkg::*;
#(
  parameter int   NREQ       = DEF_NREQ,
  parameter int   MAX_HOLD   = DEF_MAX_HOLD,
  parameter int   TURN_CYC   = DEF_TURN_CYC,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic            ppm_clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] req_dout,
  output logic [NREQ-1:0] grant,
  output logic            gpio_h0_in_o,
  input  logic            mcu_dout,
  input  logic            mcu_oe_n,
  output logic            line_rx,
  output logic            busy,
  output logic            timeout_pulse
);

  localparam int IW = clog2_min1(NREQ);
  localparam int TW = clog2_min1(MAX_HOLD);
  localparam int CW = clog2_min1(TURN_CYC + 1);

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] mask_q, mask_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [TW-1:0]   tenure_q, tenure_d;
  logic [CW-1:0]   turn_cnt_q, turn_cnt_d;
  logic            gpio_q, gpio_d;
  logic            line_rx_q, line_rx_d;
  logic            timeout_q, timeout_d;

  logic [NREQ-1:0] pick_onehot;
  logic [IW-1:0]   pick_idx;
  logic            pick_vld;
  logic [IW:0]     nxt_ptr;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .elig_i       (req & ~mask_q),
    .rr_ptr_i     (rr_ptr_q),
    .win_onehot_o (pick_onehot),
    .win_idx_o    (pick_idx),
    .win_vld_o    (pick_vld)
  );

  always_comb begin
    nxt_ptr = {1'b0, owner_q} + (IW+1)'(1);
    if (nxt_ptr == (IW+1)'(NREQ)) nxt_ptr = '0;
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    tenure_d   = tenure_q;
    turn_cnt_d = turn_cnt_q;
    gpio_d     = gpio_q;
    timeout_d  = 1'b0;
    line_rx_d  = mcu_dout;
    mask_d     = mask_q & req;
    case (state_q)
      IDLE: begin
        if (mcu_oe_n && pick_vld) begin
          state_d  = GRANT;
          grant_d  = pick_onehot;
          owner_d  = pick_idx;
          tenure_d = '0;
        end
      end
      GRANT: begin
        if (!req[owner_q] || tenure_q == TW'(MAX_HOLD - 1)) begin
          state_d    = TURN;
          grant_d    = '0;
          gpio_d     = IDLE_LEVEL;
          rr_ptr_d   = nxt_ptr[IW-1:0];
          turn_cnt_d = '0;
          // A same-edge drop of req counts as a normal release, not a timeout.
          if (req[owner_q]) begin
            timeout_d       = 1'b1;
            mask_d[owner_q] = 1'b1;
          end
        end else begin
          tenure_d = tenure_q + TW'(1);
          gpio_d   = req_dout[owner_q];
        end
      end
      TURN: begin
        if (turn_cnt_q == CW'(TURN_CYC - 1)) state_d = IDLE;
        else                                  turn_cnt_d = turn_cnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ppm_clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      mask_q     <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      tenure_q   <= '0;
      turn_cnt_q <= '0;
      gpio_q     <= IDLE_LEVEL;
      line_rx_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      mask_q     <= mask_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      tenure_q   <= tenure_d;
      turn_cnt_q <= turn_cnt_d;
      gpio_q     <= gpio_d;
      line_rx_q  <= line_rx_d;
      timeout_q  <= timeout_d;
    end
  end

  assign grant         = grant_q;
  assign gpio_h0_in_o  = gpio_q;
  assign line_rx       = line_rx_q;
  assign timeout_pulse = timeout_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_gpio_h0_arbiter.sv
// Bench for gpio_h0_arbiter: directed scenarios plus random traffic against a cycle-level reference model.
module tb_gpio_h0_arbiter;

  localparam int NR   = 4;
  localparam int MAXH = 8;
  localparam int TURN = 2;

  logic         ppm_clk;
  logic         rst_n;
  logic [NR-1:0] req, req_dout, grant;
  logic         gpio_h0_in_o, mcu_dout, mcu_oe_n, line_rx, busy, timeout_pulse;
  logic [7:0]   act;

  int n_chk = 0;
  int n_err = 0;

  gpio_h0_arbiter #(
    .NREQ       (NR),
    .MAX_HOLD   (MAXH),
    .TURN_CYC   (TURN),
    .IDLE_LEVEL (1'b1)
  ) dut (
    .ppm_clk       (ppm_clk),
    .rst_n         (rst_n),
    .req           (req),
    .req_dout      (req_dout),
    .grant         (grant),
    .gpio_h0_in_o  (gpio_h0_in_o),
    .mcu_dout      (mcu_dout),
    .mcu_oe_n      (mcu_oe_n),
    .line_rx       (line_rx),
    .busy          (busy),
    .timeout_pulse (timeout_pulse)
  );

  assign act = {grant, gpio_h0_in_o, busy, timeout_pulse, line_rx};

  initial ppm_clk = 1'b0;
  always #5 ppm_clk = ~ppm_clk;

  // Reference model: who owns the line, how long they have held it, how many gap cycles remain.
  int          m_owner, m_held, m_gap, m_ptr;
  logic [NR-1:0] m_mask;
  logic        m_gpio, m_rx, m_pulse;

  task automatic model_edge();
    logic [NR-1:0] nm;
    if (!rst_n) begin
      m_owner = -1; m_held = 0; m_gap = 0; m_ptr = 0; m_mask = '0;
      m_gpio = 1'b1; m_rx = 1'b0; m_pulse = 1'b0;
      return;
    end
    m_pulse = 1'b0;
    m_rx    = mcu_dout;
    nm      = m_mask & req;
    if (m_owner >= 0) begin
      if (!req[m_owner[1:0]] || m_held == MAXH) begin
        if (req[m_owner[1:0]]) begin
          m_pulse = 1'b1;
          nm[m_owner[1:0]] = 1'b1;
        end
        m_ptr = (m_owner + 1) % NR; m_owner = -1; m_gap = TURN; m_gpio = 1'b1;
      end else begin
        m_held++;
        m_gpio = req_dout[m_owner[1:0]];
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (mcu_oe_n) begin
      for (int k = 0; k < NR; k++) begin
        int i;
        i = (m_ptr + k) % NR;
        if (req[i[1:0]] && !m_mask[i[1:0]]) begin
          m_owner = i; m_held = 1;
          break;
        end
      end
    end
    m_mask = nm;
  endtask

  function automatic logic [7:0] exp_vec();
    logic [NR-1:0] g;
    g = (m_owner >= 0) ? (4'b0001 << m_owner[1:0]) : 4'b0000;
    return {g, m_gpio, (m_owner >= 0) || (m_gap > 0), m_pulse, m_rx};
  endfunction

  task automatic tick();
    @(posedge ppm_clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; req_dout = '0; mcu_dout = 1'b0; mcu_oe_n = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b1111; req_dout = '0; mcu_dout = 1'b1; mcu_oe_n = 1'b1;
    tick(); tick(); tick();
    n_chk++;
    if ({grant, gpio_h0_in_o, busy, timeout_pulse, line_rx} !== 8'b0000_1000) begin
      n_err++; $display("FAIL reset_state: got %b want %b", act, 8'b0000_1000);
    end
    rst_n = 1'b1; mcu_dout = 1'b0;
    tick();
    n_chk++;
    if (grant !== 4'b0001) begin
      n_err++; $display("FAIL first_grant: got %b want 0001", grant);
    end
    tick(); tick();
    rst_n = 1'b0;
    tick();
    n_chk++;
    if (grant !== 4'b0000 || timeout_pulse !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL reset_mid_tenure: got grant=%b pulse=%b busy=%b want 0000/0/0",
                        grant, timeout_pulse, busy);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] seq [$];
    int zero_run, gap_bad;
    do_reset();
    zero_run = 0; gap_bad = 0;
    for (int c = 0; c < 40 && seq.size() < 3; c++) begin
      req = 4'b1010;
      if (m_owner >= 0 && m_held == 3) req[m_owner[1:0]] = 1'b0;
      tick();
      n_chk++;
      if (act !== exp_vec()) begin
        n_err++; $display("FAIL rr_cycle: got %b want %b", act, exp_vec());
      end
      if (grant == 4'b0000) zero_run++;
      else begin
        if (grant !== seq[$] || seq.size() == 0) begin
          if (seq.size() > 0 && zero_run != TURN + 1) gap_bad++;
          seq.push_back(grant);
        end
        zero_run = 0;
      end
    end
    n_chk++;
    if (seq.size() != 3 || seq[0] !== 4'b0010 || seq[1] !== 4'b1000 || seq[2] !== 4'b0010) begin
      n_err++; $display("FAIL rr_order: got %0d grants (%b %b %b) want 0010 1000 0010",
                        seq.size(), seq.size() > 0 ? seq[0] : 4'bx,
                        seq.size() > 1 ? seq[1] : 4'bx, seq.size() > 2 ? seq[2] : 4'bx);
    end
    // Release at edge t, earliest regrant after edge t+TURN+1: TURN+1 grant-free cycles.
    n_chk++;
    if (gap_bad != 0) begin
      n_err++; $display("FAIL rr_gap: got %0d bad gaps want 0", gap_bad);
    end
  endtask

  task automatic test_timeout();
    int hi, regrant;
    logic saw;
    do_reset();
    req = 4'b0001;
    tick();
    hi = 0;
    while (grant[0] && hi < 20) begin
      hi++;
      tick();
    end
    n_chk++;
    if (hi != MAXH || timeout_pulse !== 1'b1) begin
      n_err++; $display("FAIL timeout_len: got %0d cycles pulse=%b want %0d cycles pulse=1",
                        hi, timeout_pulse, MAXH);
    end
    saw = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (grant !== 4'b0000) saw = 1'b1;
    end
    n_chk++;
    if (saw !== 1'b0) begin
      n_err++; $display("FAIL timeout_mask: got regrant=%b want 0", saw);
    end
    req = 4'b0000;
    tick();
    req = 4'b0001;
    regrant = 0;
    for (int c = 1; c <= 10 && regrant == 0; c++) begin
      tick();
      if (grant == 4'b0001) regrant = c;
    end
    n_chk++;
    if (regrant != 1) begin
      n_err++; $display("FAIL timeout_regrant: got regrant after %0d cycles want 1", regrant);
    end
  endtask

  task automatic test_mcu_own();
    logic saw;
    do_reset();
    mcu_oe_n = 1'b0; req = 4'b0100; saw = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (grant !== 4'b0000) saw = 1'b1;
    end
    n_chk++;
    if (saw !== 1'b0) begin
      n_err++; $display("FAIL mcu_hold: got grant during mcu drive want none");
    end
    mcu_oe_n = 1'b1;
    tick();
    n_chk++;
    if (grant !== 4'b0100) begin
      n_err++; $display("FAIL mcu_release: got %b want 0100", grant);
    end
  endtask

  task automatic test_datapath();
    logic [2:0] pat, got;
    pat = 3'b101;
    for (int c = 2; c >= 0; c--) begin
      req_dout[2] = pat[c];
      tick();
      got[c] = gpio_h0_in_o;
    end
    n_chk++;
    if (got !== pat) begin
      n_err++; $display("FAIL data_follow: got %b want %b", got, pat);
    end
    mcu_dout = 1'b1;
    n_chk++;
    if (line_rx !== 1'b0) begin
      n_err++; $display("FAIL rx_early: got %b want 0", line_rx);
    end
    tick();
    mcu_dout = 1'b0;
    n_chk++;
    if (line_rx !== 1'b1 || grant !== 4'b0100) begin
      n_err++; $display("FAIL rx_pulse: got rx=%b grant=%b want 1/0100", line_rx, grant);
    end
    tick();
    n_chk++;
    if (line_rx !== 1'b0) begin
      n_err++; $display("FAIL rx_fall: got %b want 0", line_rx);
    end
  endtask

  task automatic test_same_edge();
    int guard;
    do_reset();
    req = 4'b0001;
    tick();
    guard = 0;
    while (m_held < MAXH && guard < 20) begin
      tick(); guard++;
    end
    req = 4'b0000;
    tick();
    n_chk++;
    if (timeout_pulse !== 1'b0 || grant !== 4'b0000) begin
      n_err++; $display("FAIL same_edge_pulse: got pulse=%b grant=%b want 0/0000",
                        timeout_pulse, grant);
    end
    req = 4'b0001;
    tick(); tick(); tick();
    n_chk++;
    if (grant !== 4'b0001) begin
      n_err++; $display("FAIL same_edge_nomask: got %b want 0001", grant);
    end
  endtask

  task automatic test_random();
    int bad;
    do_reset();
    bad = 0;
    for (int c = 0; c < 2000; c++) begin
      for (int b = 0; b < NR; b++)
        if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
      req_dout = NR'($urandom);
      mcu_dout = 1'($urandom);
      mcu_oe_n = ($urandom_range(0, 7) != 0);
      rst_n    = ($urandom_range(0, 299) != 0);
      tick();
      n_chk++;
      if (act !== exp_vec()) begin
        n_err++; bad++;
        if (bad < 10) $display("FAIL random_cycle %0d: got %b want %b", c, act, exp_vec());
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req = '0; req_dout = '0; mcu_dout = 1'b0; mcu_oe_n = 1'b1;
    test_reset();
    test_round_robin();
    test_timeout();
    test_mcu_own();
    test_datapath();
    test_same_edge();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
